// File: rtl/vec_bank_mem.sv
// vec_bank_mem: banked scratchpad memory, the responder end of the tensorcore's
// SIMD/scalar BRAM interface. NUM_LANES banks, each holding one DATA_W word per row.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   vpu_*             full-row read / lane-masked write port (1-cycle read latency)
//   host_req_*        word-addressed host/DMA port, served only while vpu_en=0
//   host_rsp_valid    one-cycle read-data strobe, host_rdata holds the word
//   host_stall_cnt    saturating count of cycles the host request was refused
module vec_bank_mem #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned NUM_LANES   = 8,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned HOST_ADDR_W = ADDR_W + $clog2(NUM_LANES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             vpu_addr,
  input  logic [NUM_LANES*DATA_W-1:0]   vpu_din,
  output logic [NUM_LANES*DATA_W-1:0]   vpu_dout,
  input  logic                          vpu_en,
  input  logic                          vpu_we,
  input  logic [NUM_LANES-1:0]          vpu_lane_mask,
  input  logic                          host_req_valid,
  output logic                          host_req_ready,
  input  logic                          host_we,
  input  logic [HOST_ADDR_W-1:0]        host_addr,
  input  logic [DATA_W-1:0]             host_wdata,
  output logic                          host_rsp_valid,
  output logic [DATA_W-1:0]             host_rdata,
  output logic [15:0]                   host_stall_cnt
);

  localparam int unsigned ROW_W  = $clog2(DEPTH);
  localparam int unsigned LANE_W = $clog2(NUM_LANES);

  // Address decode; upper address bits are ignored so rows wrap.
  logic [ROW_W-1:0]  vpu_row;
  logic [ROW_W-1:0]  host_row;
  logic [LANE_W-1:0] host_lane;
  logic [ROW_W-1:0]  arr_row;
  logic              unused_addr_bits;

  assign vpu_row   = vpu_addr[ROW_W-1:0];
  assign host_lane = host_addr[LANE_W-1:0];
  assign host_row  = host_addr[LANE_W +: ROW_W];
  assign unused_addr_bits = ^{vpu_addr[ADDR_W-1:ROW_W], host_addr[HOST_ADDR_W-1:LANE_W+ROW_W]};

  // Arbitration: the VPU always owns the array when enabled.
  logic host_acc;
  logic vpu_wr;
  logic vpu_rd;
  logic host_wr;
  logic host_rd;

  assign host_req_ready = !vpu_en;
  assign host_acc       = host_req_valid && host_req_ready && !rst;
  assign vpu_wr         = vpu_en && vpu_we && !rst;
  assign vpu_rd         = vpu_en && !vpu_we;
  assign host_wr        = host_acc && host_we;
  assign host_rd        = host_acc && !host_we;

  // Only one requester drives the array in a cycle, so all banks share one row.
  assign arr_row = vpu_en ? vpu_row : host_row;

  logic [DATA_W-1:0] bank_rdata [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic              bank_we;
    logic [DATA_W-1:0] bank_wdata;

    // Per-bank write enable is the lane hit from whichever port owns the array.
    always_comb begin
      bank_we    = 1'b0;
      bank_wdata = host_wdata;
      if (vpu_wr) begin
        bank_we    = vpu_lane_mask[g];
        bank_wdata = vpu_din[g*DATA_W +: DATA_W];
      end else if (host_wr) begin
        bank_we    = (host_lane == LANE_W'(g));
      end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
      if (bank_we) begin
        mem[arr_row] <= bank_wdata;
      end
    end

    assign bank_rdata[g] = mem[arr_row];
  end

  // Output registers: read data is captured at the access edge and then held.
  logic [NUM_LANES*DATA_W-1:0] vpu_dout_d, vpu_dout_q;
  logic                        host_rsp_valid_d, host_rsp_valid_q;
  logic [DATA_W-1:0]           host_rdata_d, host_rdata_q;
  logic [15:0]                 host_stall_cnt_d, host_stall_cnt_q;

  always_comb begin
    vpu_dout_d       = vpu_dout_q;
    host_rsp_valid_d = host_rd;
    host_rdata_d     = host_rdata_q;
    host_stall_cnt_d = host_stall_cnt_q;
    if (vpu_rd) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        vpu_dout_d[i*DATA_W +: DATA_W] = bank_rdata[i];
      end
    end
    if (host_rd) begin
      host_rdata_d = bank_rdata[host_lane];
    end
    if (host_req_valid && !host_req_ready && (host_stall_cnt_q != 16'hFFFF)) begin
      host_stall_cnt_d = host_stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpu_dout_q       <= '0;
      host_rsp_valid_q <= 1'b0;
      host_rdata_q     <= '0;
      host_stall_cnt_q <= '0;
    end else begin
      vpu_dout_q       <= vpu_dout_d;
      host_rsp_valid_q <= host_rsp_valid_d;
      host_rdata_q     <= host_rdata_d;
      host_stall_cnt_q <= host_stall_cnt_d;
    end
  end

  assign vpu_dout       = vpu_dout_q;
  // A read accepted just before reset asserts must not be seen responding.
  assign host_rsp_valid = host_rsp_valid_q && !rst;
  assign host_rdata     = host_rdata_q;
  assign host_stall_cnt = host_stall_cnt_q;

endmodule
